led_stream_serializer: RTL



---
 rtl/led_stream_serializer.sv | 133 +++++++++++++
 1 files changed

// File: rtl/led_stream_serializer.sv
// Serialises 16-bit grey-level words MSB-first onto DAI/DEN, with per-frame word counting and idle gaps.
// Define LED_SER_PARITY_EN to append an odd-parity bit after each word's 16 data bits.
module led_stream_serializer #(
  parameter int unsigned WORDS     = 512,
  parameter int unsigned WORD_GAP  = 0,
  parameter int unsigned FRAME_GAP = 8
) (
  input  logic        DCK,
  input  logic        rst,
  input  logic [15:0] pix_data,
  input  logic        pix_valid,
  output logic        pix_ready,
  input  logic        flush,
  output logic        DAI,
  output logic        DEN,
  output logic        frame_done,
  output logic        busy
);

`ifdef LED_SER_PARITY_EN
  localparam int unsigned SHIFT_W = 17;
  localparam int unsigned BIT_W   = 5;
`else
  localparam int unsigned SHIFT_W = 16;
  localparam int unsigned BIT_W   = 4;
`endif
  localparam int unsigned WCNT_W = $clog2(WORDS);
  localparam int unsigned GAP_W  = 8;

  typedef enum logic [1:0] {IDLE, SHIFT, WGAP, FGAP} state_t;

  state_t             r_state;
  logic [SHIFT_W-1:0] r_shift;
  logic [BIT_W-1:0]   r_bit_cnt;
  logic [WCNT_W-1:0]  r_word_cnt;
  logic [GAP_W-1:0]   r_gap_cnt;
  logic               r_dai;
  logic               r_den;
  logic               r_frame_done;
  logic               r_busy;
  logic [SHIFT_W-1:0] w_load;
  logic               w_xfer;

`ifdef LED_SER_PARITY_EN
  assign w_load = {pix_data, ~^pix_data};
`else
  assign w_load = pix_data;
`endif

  // Acceptance is only possible in IDLE and never while a flush is pending.
  assign pix_ready  = (r_state == IDLE) && !flush;
  assign w_xfer     = pix_valid && pix_ready;
  assign DAI        = r_dai;
  assign DEN        = r_den;
  assign frame_done = r_frame_done;
  assign busy       = r_busy;

  always_ff @(posedge DCK or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_word_cnt   <= '0;
      r_gap_cnt    <= '0;
      r_dai        <= 1'b0;
      r_den        <= 1'b0;
      r_frame_done <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (flush) begin
        r_state    <= IDLE;
        r_bit_cnt  <= '0;
        r_word_cnt <= '0;
        r_gap_cnt  <= '0;
        r_dai      <= 1'b0;
        r_den      <= 1'b0;
        r_busy     <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            // First bit goes straight to DAI; the remainder waits in the shifter.
            if (w_xfer) begin
              r_state   <= SHIFT;
              r_shift   <= {w_load[SHIFT_W-2:0], 1'b0};
              r_dai     <= w_load[SHIFT_W-1];
              r_den     <= 1'b1;
              r_bit_cnt <= '0;
              r_busy    <= 1'b1;
            end
          end
          SHIFT: begin
            if (r_bit_cnt == BIT_W'(SHIFT_W - 1)) begin
              r_den <= 1'b0;
              r_dai <= 1'b0;
              if (r_word_cnt == WCNT_W'(WORDS - 1)) begin
                r_state      <= FGAP;
                r_word_cnt   <= '0;
                r_gap_cnt    <= GAP_W'(FRAME_GAP) - GAP_W'(1);
                r_frame_done <= 1'b1;
              end else if (WORD_GAP > 0) begin
                r_state    <= WGAP;
                r_word_cnt <= r_word_cnt + WCNT_W'(1);
                r_gap_cnt  <= GAP_W'(WORD_GAP) - GAP_W'(1);
              end else begin
                r_state    <= IDLE;
                r_word_cnt <= r_word_cnt + WCNT_W'(1);
                r_busy     <= 1'b0;
              end
            end else begin
              r_bit_cnt <= r_bit_cnt + BIT_W'(1);
              r_dai     <= r_shift[SHIFT_W-1];
              r_shift   <= {r_shift[SHIFT_W-2:0], 1'b0};
            end
          end
          WGAP, FGAP: begin
            if (r_gap_cnt == '0) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_gap_cnt <= r_gap_cnt - GAP_W'(1);
            end
          end
          default: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
